// File: rtl/otter_mem_arbiter_pkg.sv
// Shared types for the OTTER fetch/data memory arbiter.
// Response ownership encoding and memory access size codes.
package otter_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between the fetch stage, the MEM stage, the arbiter and the memory.
// slave = arbiter view, master = requesters/memory view.
interface otter_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              IF_REQ;
  logic [ADDR_W-1:0] IF_ADDR;
  logic              IF_GNT;
  logic              IF_STALL;
  logic              IF_RVALID;
  logic [31:0]       IF_RDATA;

  logic              D_REQ;
  logic              D_WE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [31:0]       D_WDATA;
  logic [1:0]        D_SIZE;
  logic              D_SIGN;
  logic              D_GNT;
  logic              D_RVALID;
  logic [31:0]       D_RDATA;

  logic              MEM_EN;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_DIN;
  logic [1:0]        MEM_SIZE;
  logic              MEM_SIGN;
  logic [31:0]       MEM_DOUT;

  modport slave (
    input  IF_REQ, IF_ADDR,
    output IF_GNT, IF_STALL, IF_RVALID, IF_RDATA,
    input  D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
    output D_GNT, D_RVALID, D_RDATA,
    output MEM_EN, MEM_WE, MEM_ADDR, MEM_DIN, MEM_SIZE, MEM_SIGN,
    input  MEM_DOUT
  );

  modport master (
    output IF_REQ, IF_ADDR,
    input  IF_GNT, IF_STALL, IF_RVALID, IF_RDATA,
    output D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
    input  D_GNT, D_RVALID, D_RDATA,
    input  MEM_EN, MEM_WE, MEM_ADDR, MEM_DIN, MEM_SIZE, MEM_SIGN,
    output MEM_DOUT
  );
endinterface

// File: rtl/otter_mem_arbiter_wait_ctr.sv
// Saturating count of consecutive cycles fetch has been denied.
// Any cycle without a fetch stall clears it.
module otter_arb_wait_ctr #(
  parameter logic [3:0] MAX = 4'd3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       stall,
  output logic [3:0] cnt
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)          cnt <= 4'd0;
    else if (!stall)     cnt <= 4'd0;
    else if (cnt != MAX) cnt <= cnt + 4'd1;
  end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Single-port memory arbiter: MEM stage wins ties until fetch has waited
// IF_MAX_WAIT cycles; read data returns to the owner one cycle after grant.
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int IF_MAX_WAIT = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  otter_mem_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_WAIT = 4'(IF_MAX_WAIT);

  logic              if_gnt, d_gnt;
  logic [3:0]        wait_cnt;
  owner_t            resp_owner, owner_nxt;
  logic              mem_en, mem_we, mem_sign;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [1:0]        mem_size;

  // Grants are gated by RST_N so requests are ignored, and outputs zero, in reset.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (RST_N) begin
      if (bus.IF_REQ && bus.D_REQ) begin
        if (wait_cnt == MAX_WAIT) if_gnt = 1'b1;
        else                      d_gnt  = 1'b1;
      end else begin
        if_gnt = bus.IF_REQ;
        d_gnt  = bus.D_REQ;
      end
    end
  end

  otter_arb_wait_ctr #(.MAX(MAX_WAIT)) u_wait (
    .CLK   (CLK),
    .RST_N (RST_N),
    .stall (bus.IF_REQ & ~if_gnt),
    .cnt   (wait_cnt)
  );

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = 32'd0;
    mem_size = 2'b00;
    mem_sign = 1'b0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = bus.IF_ADDR;
      mem_size = SZ_WORD;
    end else if (d_gnt) begin
      mem_en   = 1'b1;
      mem_we   = bus.D_WE;
      mem_addr = bus.D_ADDR;
      mem_din  = bus.D_WDATA;
      mem_size = bus.D_SIZE;
      mem_sign = bus.D_SIGN;
    end
  end

  assign bus.MEM_EN   = mem_en;
  assign bus.MEM_WE   = mem_we;
  assign bus.MEM_ADDR = mem_addr;
  assign bus.MEM_DIN  = mem_din;
  assign bus.MEM_SIZE = mem_size;
  assign bus.MEM_SIGN = mem_sign;

  // Tracks who owns the read data arriving next cycle; writes return nothing.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (if_gnt)                  owner_nxt = OWN_IF;
    else if (d_gnt && !bus.D_WE) owner_nxt = OWN_D;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) resp_owner <= OWN_NONE;
    else        resp_owner <= owner_nxt;
  end

  assign bus.IF_GNT    = if_gnt;
  assign bus.D_GNT     = d_gnt;
  assign bus.IF_STALL  = RST_N & bus.IF_REQ & ~if_gnt;
  assign bus.IF_RVALID = (resp_owner == OWN_IF);
  assign bus.D_RVALID  = (resp_owner == OWN_D);
  assign bus.IF_RDATA  = (resp_owner == OWN_IF) ? bus.MEM_DOUT : 32'd0;
  assign bus.D_RDATA   = (resp_owner == OWN_D)  ? bus.MEM_DOUT : 32'd0;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed vector bench for otter_mem_arbiter with a registered memory model.
module tb_otter_mem_arbiter;

  logic CLK;
  logic RST_N;
  int   total = 0;
  int   bad   = 0;

  otter_mem_arbiter_if #(.ADDR_W(32)) bus ();

  otter_mem_arbiter #(.ADDR_W(32), .IF_MAX_WAIT(3)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous memory: read data appears the cycle after a read strobe.
  logic [31:0] mem [logic [31:0]];
  always @(posedge CLK) begin
    if (bus.MEM_EN && !bus.MEM_WE)
      bus.MEM_DOUT <= mem.exists(bus.MEM_ADDR) ? mem[bus.MEM_ADDR] : 32'd0;
    if (bus.MEM_EN && bus.MEM_WE)
      mem[bus.MEM_ADDR] = bus.MEM_DIN;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr; logic dwe; logic [31:0] da; logic [31:0] dwd; logic [1:0] dsz; logic ds;
    logic eig; logic edg; logic est; logic een; logic ewe;
    logic [31:0] eaddr; logic [31:0] edin; logic [1:0] esz; logic es;
    logic eirv; logic [31:0] eird; logic edrv; logic [31:0] edrd; logic [3:0] ewait;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [1:0] dsz,
                       input logic ds);
    bus.IF_REQ  = ir;  bus.IF_ADDR = ia;
    bus.D_REQ   = dr;  bus.D_WE    = dwe; bus.D_ADDR = da;
    bus.D_WDATA = dwd; bus.D_SIZE  = dsz; bus.D_SIGN = ds;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".if_gnt"},    {31'd0, bus.IF_GNT},    32'd0);
    chk({tag, ".d_gnt"},     {31'd0, bus.D_GNT},     32'd0);
    chk({tag, ".if_stall"},  {31'd0, bus.IF_STALL},  32'd0);
    chk({tag, ".mem_en"},    {31'd0, bus.MEM_EN},    32'd0);
    chk({tag, ".mem_we"},    {31'd0, bus.MEM_WE},    32'd0);
    chk({tag, ".mem_addr"},  bus.MEM_ADDR,           32'd0);
    chk({tag, ".mem_din"},   bus.MEM_DIN,            32'd0);
    chk({tag, ".mem_size"},  {30'd0, bus.MEM_SIZE},  32'd0);
    chk({tag, ".mem_sign"},  {31'd0, bus.MEM_SIGN},  32'd0);
    chk({tag, ".if_rvalid"}, {31'd0, bus.IF_RVALID}, 32'd0);
    chk({tag, ".if_rdata"},  bus.IF_RDATA,           32'd0);
    chk({tag, ".d_rvalid"},  {31'd0, bus.D_RVALID},  32'd0);
    chk({tag, ".d_rdata"},   bus.D_RDATA,            32'd0);
  endtask

  initial begin
    mem[32'h100]  = 32'h0050_0093;
    mem[32'h104]  = 32'h00A0_0113;
    mem[32'h2000] = 32'h1122_3344;
    mem[32'h2004] = 32'hCAFE_F00D;

    //          ir ia         dr we da          dwd           sz     s   ig ed st en we addr        din           sz     s   irv ird           drv drd           wait
    vt[0]  = '{1, 32'h100, 0, 0, 32'h0,    32'h0,        2'b00, 0,  1, 0, 0, 1, 0, 32'h100,  32'h0,        2'b10, 0,  0, 32'h0,         0, 32'h0,         4'd0};
    vt[1]  = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        2'b00, 0,  0, 0, 0, 0, 0, 32'h0,    32'h0,        2'b00, 0,  1, 32'h0050_0093, 0, 32'h0,         4'd0};
    vt[2]  = '{1, 32'h104, 1, 0, 32'h2000, 32'h0,        2'b10, 0,  0, 1, 1, 1, 0, 32'h2000, 32'h0,        2'b10, 0,  0, 32'h0,         0, 32'h0,         4'd0};
    vt[3]  = '{1, 32'h104, 0, 0, 32'h0,    32'h0,        2'b00, 0,  1, 0, 0, 1, 0, 32'h104,  32'h0,        2'b10, 0,  0, 32'h0,         1, 32'h1122_3344, 4'd1};
    vt[4]  = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        2'b00, 0,  0, 0, 0, 0, 0, 32'h0,    32'h0,        2'b00, 0,  1, 32'h00A0_0113, 0, 32'h0,         4'd0};
    vt[5]  = '{1, 32'h104, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 0, 1, 1, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 0, 32'h0,         0, 32'h0,         4'd0};
    vt[6]  = '{1, 32'h104, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 0, 1, 1, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 0, 32'h0,         1, 32'hCAFE_F00D, 4'd1};
    vt[7]  = '{1, 32'h104, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 0, 1, 1, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 0, 32'h0,         1, 32'hCAFE_F00D, 4'd2};
    vt[8]  = '{1, 32'h104, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 1, 0, 0, 1, 0, 32'h104,  32'h0,        2'b10, 0,  0, 32'h0,         1, 32'hCAFE_F00D, 4'd3};
    vt[9]  = '{1, 32'h104, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 0, 1, 1, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 1, 32'h00A0_0113, 0, 32'h0,         4'd0};
    vt[10] = '{1, 32'h104, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 0, 1, 1, 1, 0, 32'h2004, 32'h5555_5555, 2'b01, 1, 0, 32'h0,         1, 32'hCAFE_F00D, 4'd1};
    vt[11] = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        2'b00, 0,  0, 0, 0, 0, 0, 32'h0,    32'h0,        2'b00, 0,  0, 32'h0,         1, 32'hCAFE_F00D, 4'd2};
    vt[12] = '{0, 32'h0,   1, 1, 32'h3000, 32'hDEAD_BEEF, 2'b00, 0, 0, 1, 0, 1, 1, 32'h3000, 32'hDEAD_BEEF, 2'b00, 0, 0, 32'h0,         0, 32'h0,         4'd0};
    vt[13] = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        2'b00, 0,  0, 0, 0, 0, 0, 32'h0,    32'h0,        2'b00, 0,  0, 32'h0,         0, 32'h0,         4'd0};
    vt[14] = '{0, 32'h0,   1, 0, 32'h2000, 32'h0,        2'b01, 0,  0, 1, 0, 1, 0, 32'h2000, 32'h0,        2'b01, 0,  0, 32'h0,         0, 32'h0,         4'd0};
    vt[15] = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        2'b00, 0,  0, 0, 0, 0, 0, 32'h0,    32'h0,        2'b00, 0,  0, 32'h0,         1, 32'h1122_3344, 4'd0};

    // Reset with both requesters asserted: everything must read zero.
    RST_N = 1'b0;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h3000, 32'h1234_5678, 2'b10, 1'b1);
    #2;
    chk_all_zero("rst");
    chk("rst.wait", {28'd0, dut.wait_cnt}, 32'd0);
    @(posedge CLK); #1;
    idle();
    RST_N = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string t;
      @(posedge CLK); #1;
      drive(vt[i].ir, vt[i].ia, vt[i].dr, vt[i].dwe, vt[i].da, vt[i].dwd, vt[i].dsz, vt[i].ds);
      #2;
      t = $sformatf("v%0d", i);
      chk({t, ".if_gnt"},    {31'd0, bus.IF_GNT},    {31'd0, vt[i].eig});
      chk({t, ".d_gnt"},     {31'd0, bus.D_GNT},     {31'd0, vt[i].edg});
      chk({t, ".if_stall"},  {31'd0, bus.IF_STALL},  {31'd0, vt[i].est});
      chk({t, ".mem_en"},    {31'd0, bus.MEM_EN},    {31'd0, vt[i].een});
      chk({t, ".mem_we"},    {31'd0, bus.MEM_WE},    {31'd0, vt[i].ewe});
      chk({t, ".mem_addr"},  bus.MEM_ADDR,           vt[i].eaddr);
      chk({t, ".mem_din"},   bus.MEM_DIN,            vt[i].edin);
      chk({t, ".mem_size"},  {30'd0, bus.MEM_SIZE},  {30'd0, vt[i].esz});
      chk({t, ".mem_sign"},  {31'd0, bus.MEM_SIGN},  {31'd0, vt[i].es});
      chk({t, ".if_rvalid"}, {31'd0, bus.IF_RVALID}, {31'd0, vt[i].eirv});
      chk({t, ".if_rdata"},  bus.IF_RDATA,           vt[i].eird);
      chk({t, ".d_rvalid"},  {31'd0, bus.D_RVALID},  {31'd0, vt[i].edrv});
      chk({t, ".d_rdata"},   bus.D_RDATA,            vt[i].edrd);
      chk({t, ".wait"},      {28'd0, dut.wait_cnt},  {28'd0, vt[i].ewait});
    end

    // Reset lands inside a grant cycle after fetch has been stalling.
    @(posedge CLK); #1;
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'h0, 2'b10, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("ra.wait_pre", {28'd0, dut.wait_cnt}, 32'd2);
    RST_N = 1'b0;
    #1;
    chk_all_zero("ra");
    chk("ra.wait", {28'd0, dut.wait_cnt}, 32'd0);
    @(posedge CLK); #1;
    idle();
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("ra.if_rvalid_after", {31'd0, bus.IF_RVALID}, 32'd0);
    chk("ra.d_rvalid_after",  {31'd0, bus.D_RVALID},  32'd0);

    // Read granted, then reset asserts mid-cycle while its response is out.
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    #2;
    chk("rb.if_gnt", {31'd0, bus.IF_GNT}, 32'd1);
    @(posedge CLK); #1;
    idle();
    chk("rb.if_rvalid_pre", {31'd0, bus.IF_RVALID}, 32'd1);
    chk("rb.if_rdata_pre",  bus.IF_RDATA, 32'h0050_0093);
    #1;
    RST_N = 1'b0;
    #1;
    chk("rb.if_rvalid_rst", {31'd0, bus.IF_RVALID}, 32'd0);
    chk("rb.if_rdata_rst",  bus.IF_RDATA, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rb.if_rvalid_post", {31'd0, bus.IF_RVALID}, 32'd0);
    chk("rb.if_rdata_post",  bus.IF_RDATA, 32'd0);
    drive(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    #2;
    chk("rb.if_gnt_new", {31'd0, bus.IF_GNT}, 32'd1);
    @(posedge CLK); #1;
    idle();
    chk("rb.if_rvalid_new", {31'd0, bus.IF_RVALID}, 32'd1);
    chk("rb.if_rdata_new",  bus.IF_RDATA, 32'h00A0_0113);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares one single-ported synchronous memory between two requesters in the pipelined OTTER CPU.
- Requester 1 is the instruction-fetch stage, which only reads words.
- Requester 2 is the MEM stage, which reads or writes with a size and sign.
- Grants one requester per cycle, routes the 1-cycle-latency read data back to its owner, and stalls the fetch side when denied. A bounded-wait counter keeps fetch from starving.

Parameters:
- ADDR_W, 32, byte-address width for both requesters and the memory side.
- IF_MAX_WAIT, 3, consecutive cycles fetch may be denied before it is forced priority (range 1..15).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IF_REQ  in  1  fetch read request.
- IF_ADDR  in  ADDR_W  fetch byte address (word aligned).
- IF_GNT  out  1  fetch access accepted this cycle.
- IF_STALL  out  1  equals IF_REQ & ~IF_GNT; holds the PC and IF/DE register.
- IF_RVALID  out  1  IF_RDATA valid this cycle.
- IF_RDATA  out  32  fetched instruction.
- D_REQ  in  1  data request.
- D_WE  in  1  1 = write, 0 = read.
- D_ADDR  in  ADDR_W  data byte address.
- D_WDATA  in  32  store data.
- D_SIZE  in  2  00 = byte, 01 = half, 10 = word.
- D_SIGN  in  1  1 = zero-extend (funct3[2]).
- D_GNT  out  1  data access accepted this cycle.
- D_RVALID  out  1  D_RDATA valid this cycle.
- D_RDATA  out  32  load data.
- MEM_EN  out  1  memory access strobe.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_DIN  out  32  memory write data.
- MEM_SIZE  out  2  memory access size.
- MEM_SIGN  out  1  memory sign control.
- MEM_DOUT  in  32  read data, valid 1 cycle after MEM_EN & ~MEM_WE.

Behaviour:
- Grant is combinational from the requests and registered state. Address, data and control pass combinationally to MEM_* in the grant cycle.
- Arbitration, evaluated each cycle:
  - Only one requester: it is granted.
  - Both requesting and wait_cnt < IF_MAX_WAIT: D is granted (the older instruction wins).
  - Both requesting and wait_cnt == IF_MAX_WAIT: IF is granted.
  - Neither requesting: MEM_EN = 0 and MEM_* address/data = 0.
- MEM_* for an IF grant: MEM_WE = 0, MEM_SIZE = 10, MEM_SIGN = 0.
- MEM_* for a D grant: D_WE, D_ADDR, D_WDATA, D_SIZE and D_SIGN are forwarded.
- wait_cnt, 4-bit register:
  - Increments, saturating at IF_MAX_WAIT, on cycles with IF_REQ & ~IF_GNT.
  - Clears on IF_GNT or when IF_REQ = 0.
- resp_owner register, type owner_t, states OWN_NONE, OWN_IF, OWN_D; next value each cycle:
  - OWN_IF after an IF grant.
  - OWN_D after a D read grant.
  - OWN_NONE after a D write grant or no grant.
- Response path, cycle N+1 after the grant:
  - resp_owner == OWN_IF: IF_RVALID = 1, IF_RDATA = MEM_DOUT.
  - resp_owner == OWN_D: D_RVALID = 1, D_RDATA = MEM_DOUT.
  - A non-owner's RDATA output is driven to 0.
- Writes produce no RVALID. A write completes in its grant cycle.
- Back-to-back accesses sustain one per cycle. A new grant may issue in the same cycle a response returns.
- Requesters must hold REQ and address stable until granted; the arbiter does not latch requests.
- Reset (RST_N low, asynchronous):
  - Outputs go to 0 immediately: all GNT, RVALID, RDATA, MEM_EN, MEM_WE, MEM_ADDR, MEM_DIN, MEM_SIZE, MEM_SIGN, and IF_STALL.
  - wait_cnt = 0, resp_owner = OWN_NONE.
  - Requests are ignored while RST_N is low.
  - A read granted in the cycle before reset asserts is dropped; no RVALID follows after reset releases.
- First cycle after reset release: normal arbitration.

Decomposition:
- Package otter_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_IF, OWN_D}.
  - Size constants SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
- No sub-module needed. If one is split out, name it otter_arb_wait_ctr (the saturating wait counter with clear).

Test Plan:
- IF_REQ only, IF_ADDR = 0x100, memory returns 0x00500093 -> IF_GNT = 1 in the same cycle; next cycle IF_RVALID = 1, IF_RDATA = 0x00500093; D_RVALID = 0.
- IF_REQ and D_REQ (read, 0x2000, word) together, IF_MAX_WAIT = 3 -> D_GNT = 1 and IF_STALL = 1 in cycle 0; IF_GNT = 1 in cycle 1; responses return to D in cycle 1 and to IF in cycle 2.
- Both requesting continuously for 6 cycles -> grant sequence D, D, D, IF, D, D; wait_cnt reads 0, 1, 2, 3, 0, 1.
- D write (0x3000, data 0xDEADBEEF, size 00) with IF idle -> MEM_WE = 1, MEM_SIZE = 00, MEM_DIN = 0xDEADBEEF; no RVALID in the following cycle.
- Load (D_SIZE = 01, D_SIGN = 0) -> MEM_SIZE = 01, MEM_SIGN = 0; D_RDATA = MEM_DOUT one cycle later.
- IF read granted, then RST_N pulled low mid-cycle before the response -> all outputs 0 immediately; after release IF_RVALID stays 0 until a new grant.
